// File: rtl/fetch_queue_pkg.sv
// Shared core definitions for the fetch-to-decode instruction queue.
// Holds the default datapath width, the fetch entry layout and the past-end marker.
package fetch_queue_pkg;

    localparam int XLEN = 32;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    // Fetch emits an all-zero word once it runs past the end of the ROM.
    localparam logic [XLEN-1:0] NOP_PAST_END = 32'b0;

endpackage

// File: rtl/fetch_queue_mem.sv
// Entry storage for fetch_queue: one synchronous write port and one
// asynchronous read port. Contents are never reset.
module fetch_queue_mem #(
    parameter int DEPTH = 4,
    parameter int W     = 64
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Circular instruction queue between fetch and decode with flush on redirect
// and end-of-program drain detection.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [XLEN-1:0]            in_pc,
    input  logic [XLEN-1:0]            in_instr,
    input  logic                       in_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_pc,
    output logic [XLEN-1:0]            out_instr,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       drained
);

    import fetch_queue_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              end_seen;
    logic              full;
    logic              empty;
    logic              push;
    logic              write_en;
    logic              pop;
    logic [2*XLEN-1:0] rd_data;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    assign in_ready  = !full;
    assign out_valid = !empty;

    assign push = in_valid && in_ready && !flush;
    // The past-end word is accepted so fetch can move on, but never stored.
    assign write_en = push && (in_instr != XLEN'(NOP_PAST_END));
    assign pop      = out_valid && out_ready && !flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            end_seen <= 1'b0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            end_seen <= 1'b0;
        end else begin
            if (write_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({write_en, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (in_last) begin
                end_seen <= 1'b1;
            end
        end
    end

    fetch_queue_mem #(
        .DEPTH (DEPTH),
        .W     (2 * XLEN)
    ) u_mem (
        .clk   (clk),
        .we    (write_en),
        .waddr (wr_ptr),
        .wdata ({in_pc, in_instr}),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    // Storage is not cleared, so stale head data is masked whenever empty.
    assign out_pc    = empty ? '0 : rd_data[2*XLEN-1:XLEN];
    assign out_instr = empty ? '0 : rd_data[XLEN-1:0];

    assign drained = end_seen && empty;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed-vector bench for fetch_queue with hand-computed expectations.
module tb_fetch_queue;

    import fetch_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam int XW    = 32;

    logic          clk;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [XW-1:0] in_pc;
    logic [XW-1:0] in_instr;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [XW-1:0] out_pc;
    logic [XW-1:0] out_instr;
    logic [2:0]    count;
    logic          drained;

    int n_checks = 0;
    int n_errors = 0;

    fetch_queue #(
        .DEPTH (DEPTH),
        .XLEN  (XW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .count     (count),
        .drained   (drained)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [XW-1:0] pc, input logic [XW-1:0] instr);
        in_valid = 1'b1;
        in_pc    = pc;
        in_instr = instr;
        step();
        in_valid = 1'b0;
    endtask

    fetch_entry_t vec [4];

    initial begin
        vec[0] = '{pc: 32'h0, instr: 32'h0000_0013};
        vec[1] = '{pc: 32'h4, instr: 32'h0010_0093};
        vec[2] = '{pc: 32'h8, instr: 32'h0020_0113};
        vec[3] = '{pc: 32'hC, instr: 32'h0030_0193};

        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_pc     = '0;
        in_instr  = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        #12;
        reset = 1'b0;
        step();

        check("rst_count", 64'(count), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_pc", 64'(out_pc), 64'd0);
        check("rst_out_instr", 64'(out_instr), 64'd0);
        check("rst_drained", 64'(drained), 64'd0);

        // Fill with decode stalled, then drain in order.
        for (int i = 0; i < 4; i++) begin
            push_one(vec[i].pc, vec[i].instr);
            if (i == 0) check("no_bypass_valid", 64'(out_valid), 64'd1);
        end
        check("fill_count", 64'(count), 64'd4);
        check("fill_in_ready", 64'(in_ready), 64'd0);
        check("fill_head_instr", 64'(out_instr), 64'h0000_0013);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("pop%0d_pc", i), 64'(out_pc), 64'(vec[i].pc));
            check($sformatf("pop%0d_instr", i), 64'(out_instr), 64'(vec[i].instr));
            step();
            if (i == 0) check("full_pop_in_ready", 64'(in_ready), 64'd1);
        end
        out_ready = 1'b0;
        check("empty_out_valid", 64'(out_valid), 64'd0);
        check("empty_out_pc", 64'(out_pc), 64'd0);
        check("empty_count", 64'(count), 64'd0);

        // Steady push+pop at occupancy 2, pointers wrap several times.
        push_one(32'h100, 32'hA000_0100);
        push_one(32'h104, 32'hA000_0104);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int k = 0; k < 10; k++) begin
            in_pc    = 32'h108 + 32'(4 * k);
            in_instr = 32'hA000_0108 + 32'(4 * k);
            check($sformatf("stream%0d_pc", k), 64'(out_pc), 64'(32'h100 + 32'(4 * k)));
            step();
            check($sformatf("stream%0d_count", k), 64'(count), 64'd2);
        end
        in_valid = 1'b0;
        check("stream_tail0_pc", 64'(out_pc), 64'h128);
        check("stream_tail0_instr", 64'(out_instr), 64'hA000_0128);
        step();
        check("stream_tail1_pc", 64'(out_pc), 64'h12C);
        step();
        check("stream_done_count", 64'(count), 64'd0);
        out_ready = 1'b0;

        // Flush a full queue while fetch is still presenting.
        for (int i = 0; i < 4; i++) push_one(32'h200 + 32'(4 * i), 32'hB000_0000 + 32'(i));
        check("pre_flush_count", 64'(count), 64'd4);
        in_valid = 1'b1;
        in_pc    = 32'hAAA;
        in_instr = 32'hBBBB_BBBB;
        flush    = 1'b1;
        out_ready = 1'b1;
        step();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("flush_count", 64'(count), 64'd0);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_out_pc", 64'(out_pc), 64'd0);
        push_one(32'h300, 32'h0000_0033);
        check("post_flush_head", 64'(out_pc), 64'h300);
        check("post_flush_count", 64'(count), 64'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Past-end word is accepted but not stored; drain then reports.
        push_one(32'h400, 32'h0000_0413);
        push_one(32'h404, 32'h0000_0493);
        in_valid = 1'b1;
        in_pc    = 32'h408;
        in_instr = 32'h0;
        in_last  = 1'b1;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("end_count", 64'(count), 64'd2);
        check("end_drained", 64'(drained), 64'd0);
        out_ready = 1'b1;
        check("end_head_pc", 64'(out_pc), 64'h400);
        step();
        check("end_pop1_drained", 64'(drained), 64'd0);
        check("end_pop1_pc", 64'(out_pc), 64'h404);
        step();
        out_ready = 1'b0;
        check("end_pop2_count", 64'(count), 64'd0);
        check("end_pop2_drained", 64'(drained), 64'd1);
        step();
        check("end_sticky_drained", 64'(drained), 64'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_clears_drained", 64'(drained), 64'd0);

        // Asynchronous reset mid-stream at occupancy 3.
        push_one(32'h500, 32'h0000_0513);
        push_one(32'h504, 32'h0000_0593);
        in_last = 1'b1;
        push_one(32'h508, 32'h0000_0613);
        in_last = 1'b0;
        check("pre_reset_count", 64'(count), 64'd3);
        #3;
        reset = 1'b1;
        #1;
        check("async_rst_count", 64'(count), 64'd0);
        check("async_rst_out_valid", 64'(out_valid), 64'd0);
        check("async_rst_in_ready", 64'(in_ready), 64'd1);
        check("async_rst_out_pc", 64'(out_pc), 64'd0);
        check("async_rst_drained", 64'(drained), 64'd0);
        #2;
        reset = 1'b0;
        step();

        // in_last together with flush must not arm end-of-stream.
        in_last = 1'b1;
        flush   = 1'b1;
        step();
        in_last = 1'b0;
        flush   = 1'b0;
        check("last_flush_drained", 64'(drained), 64'd0);
        push_one(32'h600, 32'h0000_0693);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("last_flush_empty_count", 64'(count), 64'd0);
        check("last_flush_empty_drained", 64'(drained), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction queue between the fetch stage and decode. Buffers fetched instruction/PC pairs in a small circular FIFO, decoupling fetch from decode back-pressure, discards all buffered entries on a control-flow redirect, and reports when the program stream has fully drained. Fetch pushes through a valid/ready handshake; decode pops through a second valid/ready handshake.

## Interface
- DEPTH, 4, number of entries; power of two, minimum 2
- XLEN, 32, width of PC and instruction fields
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high
- flush  input  1  synchronous discard of all entries and end-of-stream state
- in_valid  input  1  fetch presents an entry
- in_ready  output  1  queue can accept; equals !full
- in_pc  input  XLEN  PC of presented instruction
- in_instr  input  XLEN  presented instruction word
- in_last  input  1  fetch has passed end of ROM (fetch_complete level)
- out_valid  output  1  queue holds at least one entry; equals !empty
- out_ready  input  1  decode accepts head entry
- out_pc  output  XLEN  head PC; 0 when empty
- out_instr  output  XLEN  head instruction; 0 when empty
- count  output  $clog2(DEPTH)+1  occupancy, 0..DEPTH
- drained  output  1  end seen and queue empty

## Operation
- Push = in_valid && in_ready && !flush. Pop = out_valid && out_ready && !flush.
- Push writes {in_pc, in_instr} at wr_ptr, wr_ptr increments. Exception: in_instr == 0 (fetch's past-end word) completes the handshake but is not written; pointers and count unchanged.
- Pop advances rd_ptr. Head entry is always mem[rd_ptr].
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH; full/empty come from count only.
- Simultaneous push and pop (possible only when 0 < count < DEPTH): both happen, count unchanged.
- end_seen: sticky, set on any cycle with in_last = 1 and no flush; cleared by flush or reset.
- drained = end_seen && (count == 0).
- flush: highest priority. Same cycle push and pop are ignored; next cycle count = 0, wr_ptr = rd_ptr = 0, end_seen = 0. Storage contents not cleared.
- No bypass: entry pushed into empty queue is visible on out_* the following cycle.

## Timing
- Reset values: count 0, pointers 0, end_seen 0 → in_ready 1, out_valid 0, out_pc 0, out_instr 0, drained 0.
- Reset asserted mid-operation discards everything immediately (asynchronous); storage need not reset.
- Push-to-out_valid latency: 1 cycle. Pop-to-next-head: 1 cycle.
- in_ready and out_valid depend only on registered count — no combinational path from out_ready to in_ready or from in_valid to out_valid.
- out_pc/out_instr are combinational reads of registered storage, masked to 0 when count == 0.
- Full: in_ready 0; pop in that cycle frees a slot, in_ready returns 1 next cycle.
- Empty: out_ready ignored.
- in_last and flush in same cycle: flush wins, end_seen stays 0.

## Structure
- Shared package (core pkg): XLEN, fetch-entry struct {pc, instr}, constant NOP_PAST_END = 32'b0.
- One sub-module natural: fetch_queue_mem, DEPTH x (2*XLEN) register array with one write port and one asynchronous read port; pointer/count/end logic stays in fetch_queue.

## Test plan
- Reset then push pc 0x0/0x4/0x8/0xC (instr 0x00000013, 0x00100093, 0x00200113, 0x00300193) with out_ready 0 → count 4, in_ready 0; raise out_ready → pops in order 0x0..0xC, one per cycle, then out_valid 0, out_pc 0.
- Continuous push and pop at count 2 for 10 cycles → count stays 2, pointers wrap past DEPTH, output order equals input order.
- Full queue, assert flush with in_valid 1 → next cycle count 0, out_valid 0, pushed entry absent.
- Push two entries, then in_instr 0 with in_last 1 → count 2, drained 0; pop both → drained 1 the cycle count reaches 0.
- Assert reset asynchronously mid-stream at count 3 → outputs at reset values before next clock edge; drained 0.
- Flush in the same cycle as in_last 1 → end_seen stays 0, drained stays 0 after queue empties.
